// File: rtl/subtrator_placar_pkg.sv
// subtrator_placar_pkg: shared FSM state type and default widths for the serial score subtractor.
// Rev 1.0
`default_nettype none

package subtrator_placar_pkg;

  localparam int SCORE_W_DEF = 7;
  localparam int AMT_W_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/subtrator_placar_subtrator1bt.sv
// subtrator1bt: single-bit full subtractor (D = A - B - Bin, Bout = borrow out).
// Rev 1.0
`default_nettype none

module subtrator1bt
  import subtrator_placar_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~A & Bin) | (B & Bin);

endmodule

`default_nettype wire

// File: rtl/subtrator_placar.sv
// subtrator_placar: bit-serial score subtractor, one bit per cycle, LSB first.
// Macro UNDERFLOW_SAT_EN clamps an underflowing result to 0 instead of wrapping. Rev 1.0
`default_nettype none

module subtrator_placar
  import subtrator_placar_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int AMT_W   = AMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [SCORE_W-1:0] load_val,
  input  logic               start,
  input  logic [AMT_W-1:0]   B,
  output logic [SCORE_W-1:0] S,
  output logic               busy,
  output logic               done,
  output logic               Bout
);

  localparam int IDX_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCORE_W - 1);

  state_t             r_state;
  logic [SCORE_W-1:0] r_s;
  logic [SCORE_W-1:0] r_a;
  logic [SCORE_W-1:0] r_opnd;
  logic [SCORE_W-1:0] r_res;
  logic [IDX_W-1:0]   r_idx;
  logic               r_borrow;
  logic               r_busy;
  logic               r_done;
  logic               r_bout;

  logic w_d;
  logic w_bout;

  // One full subtractor shared across all bit positions via the shift registers.
  subtrator1bt u_sub (
    .A    (r_a[0]),
    .B    (r_opnd[0]),
    .Bin  (r_borrow),
    .D    (w_d),
    .Bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_a      <= '0;
      r_opnd   <= '0;
      r_res    <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bout   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_s    <= load_val;
            r_bout <= 1'b0;
          end else if (start && !r_busy) begin
            r_opnd   <= SCORE_W'(B);
            r_a      <= r_s;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_res    <= {w_d, r_res[SCORE_W-1:1]};
          r_a      <= r_a >> 1;
          r_opnd   <= r_opnd >> 1;
          r_borrow <= w_bout;
          r_idx    <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
          end
        end
        DONE: begin
`ifdef UNDERFLOW_SAT_EN
          r_s <= r_borrow ? '0 : r_res;
`else
          r_s <= r_res;
`endif
          r_bout  <= r_borrow;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign S    = r_s;
  assign busy = r_busy;
  assign done = r_done;
  assign Bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_subtrator_placar.sv
// tb_subtrator_placar: directed vectors with a scoreboard queue checked by a done-driven monitor.
`default_nettype none

module tb_subtrator_placar;

  localparam int SW = 7;
  localparam int AW = 2;
  localparam int LAT = SW + 1;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [SW-1:0] load_val;
  logic          start;
  logic [AW-1:0] B;
  logic [SW-1:0] S;
  logic          busy;
  logic          done;
  logic          Bout;

  typedef struct {
    int s;
    int bout;
    int t_start;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  subtrator_placar #(.SCORE_W(SW), .AMT_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .B        (B),
    .S        (S),
    .busy     (busy),
    .done     (done),
    .Bout     (Bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        chk("done_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("S_result", int'(S), e.s);
          chk("Bout_result", int'(Bout), e.bout);
          chk("latency", cyc - e.t_start, LAT);
        end
      end
    end
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    load = 1'b1;
    load_val = SW'(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start(input int b, input bit push, input int es, input int eb);
    @(negedge clk);
    start = 1'b1;
    B = AW'(b);
    if (push) begin
      exp_t e;
      e.s = es;
      e.bout = eb;
      e.t_start = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    cyc = 0;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    load = 1'b0;
    load_val = '0;
    start = 1'b0;
    B = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_S", int'(S), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_Bout", int'(Bout), 0);
    rst_n = 1'b1;

    // 45 - 3 = 42
    do_load(45);
    chk("load_S", int'(S), 45);
    do_start(3, 1'b1, 42, 0);
    chk("busy_calc", int'(busy), 1);
    chk("S_stable_calc", int'(S), 45);
    drain(20);
    chk("busy_idle", int'(busy), 0);

    // 2 - 3 underflows
    do_load(2);
`ifdef UNDERFLOW_SAT_EN
    do_start(3, 1'b1, 0, 1);
`else
    do_start(3, 1'b1, 127, 1);
`endif
    drain(20);

    // Load clears Bout; a second start while busy is dropped
    do_load(10);
    chk("load_clears_Bout", int'(Bout), 0);
    do_start(2, 1'b1, 8, 0);
    @(negedge clk);
    start = 1'b1;
    B = 2'd3;
    @(negedge clk);
    start = 1'b0;
    drain(20);
    repeat (LAT + 2) @(negedge clk);
    chk("single_done_S", int'(S), 8);

    // Reset mid-CALC aborts without done
    do_load(50);
    do_start(1, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_S", int'(S), 0);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    chk("abort_S", int'(S), 0);
    chk("abort_busy", int'(busy), 0);

    // load and start together: load wins
    @(negedge clk);
    load = 1'b1;
    load_val = 7'd20;
    start = 1'b1;
    B = 2'd1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    chk("load_wins_busy", int'(busy), 0);
    repeat (LAT + 2) @(negedge clk);
    chk("load_wins_S", int'(S), 20);
    chk("load_wins_busy_late", int'(busy), 0);

    // B = 0 runs full sequence; load while busy ignored
    do_load(7);
    do_start(0, 1'b1, 7, 0);
    load = 1'b1;
    load_val = 7'd99;
    @(negedge clk);
    load = 1'b0;
    drain(20);
    chk("load_busy_ignored", int'(S), 7);

    // 127 - 3 = 124, exercises the top bit
    do_load(127);
    do_start(3, 1'b1, 124, 0);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
